// File: rtl/clb_cfg_pkg.sv
// Shared types and frame layout for the CLB configuration loader.
// The packed frame struct mirrors the wire order and is reused by the CLB wrapper.
package clb_cfg_pkg;

    localparam int CFG_W = 37;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } cfg_state_e;

    localparam int MEM_LSB    = 0;
    localparam int MEM_W      = 16;
    localparam int COMB_LSB   = 16;
    localparam int COMB_W     = 2;
    localparam int MUX2_LSB   = 18;
    localparam int MUX3_LSB   = 20;
    localparam int MUX4_LSB   = 22;
    localparam int MUX5_LSB   = 24;
    localparam int MUX6_LSB   = 26;
    localparam int MUX_W      = 2;
    localparam int O2M0_LSB   = 28;
    localparam int O2M1_LSB   = 31;
    localparam int O2M_W      = 3;
    localparam int DQMUX1_BIT = 34;
    localparam int DQMUX2_BIT = 35;
    localparam int FOL_BIT    = 36;

    typedef struct packed {
        logic             floporlatch;
        logic             dqmux2;
        logic             dqmux1;
        logic [O2M_W-1:0] o2m_1;
        logic [O2M_W-1:0] o2m_0;
        logic [MUX_W-1:0] mux6sel;
        logic [MUX_W-1:0] mux5sel;
        logic [MUX_W-1:0] mux4sel;
        logic [MUX_W-1:0] mux3sel;
        logic [MUX_W-1:0] mux2sel;
        logic [COMB_W-1:0] comboption;
        logic [MEM_W-1:0] mem;
    } clb_frame_t;

    // True when the field constants tile the frame contiguously with no gaps.
    function automatic bit layout_ok();
        return (COMB_LSB == MEM_LSB + MEM_W) && (MUX2_LSB == COMB_LSB + COMB_W) &&
               (MUX3_LSB == MUX2_LSB + MUX_W) && (MUX4_LSB == MUX3_LSB + MUX_W) &&
               (MUX5_LSB == MUX4_LSB + MUX_W) && (MUX6_LSB == MUX5_LSB + MUX_W) &&
               (O2M0_LSB == MUX6_LSB + MUX_W) && (O2M1_LSB == O2M0_LSB + O2M_W) &&
               (DQMUX1_BIT == O2M1_LSB + O2M_W) && (DQMUX2_BIT == DQMUX1_BIT + 1) &&
               (FOL_BIT == DQMUX2_BIT + 1) && (FOL_BIT == CFG_W - 1) &&
               ($bits(clb_frame_t) == CFG_W);
    endfunction

endpackage

// File: rtl/clb_cfg_shifter.sv
// Frame shift register with bit counter and running even parity.
// Bits arrive LSB-first; the bit after the W-th payload bit is the parity bit.
module clb_cfg_shifter
    import clb_cfg_pkg::*;
#(
    parameter int W = CFG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         din,
    input  logic         clr,
    output logic         frame_full,
    output logic         parity_ok,
    output logic [W-1:0] payload
);

    if (W + 1 > 63) begin : g_bad_width
        $error("clb_cfg_shifter: W+1 must fit a 6-bit bit counter");
    end
    if (!layout_ok()) begin : g_bad_layout
        $error("clb_cfg_shifter: frame field constants do not tile the frame");
    end

    logic [5:0] bitcnt;
    logic       parity_acc;
    logic       at_parity;

    assign at_parity  = (bitcnt == 6'(W));
    assign frame_full = shift_en && at_parity;
    assign parity_ok  = !(parity_acc ^ din);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt     <= '0;
            parity_acc <= 1'b0;
            payload    <= '0;
        end else if (clr) begin
            bitcnt     <= '0;
            parity_acc <= 1'b0;
        end else if (shift_en) begin
            if (at_parity) begin
                bitcnt     <= '0;
                parity_acc <= 1'b0;
            end else begin
                // After W shifts the first bit received sits at payload[0].
                payload    <= {din, payload[W-1:1]};
                bitcnt     <= bitcnt + 6'd1;
                parity_acc <= parity_acc ^ din;
            end
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: hunts a sync word, then shifts, parity-checks
// and commits one frame per CLB with a one-hot write strobe.
module clb_cfg_loader #(
    parameter int         NUM_CLB  = 4,
    parameter int         CFG_W    = 37,
    parameter logic [7:0] SYNC_PAT = 8'hB5
) (
    input  logic               K,
    input  logic               RN,
    input  logic               START,
    input  logic               DIN,
    input  logic               DVALID,
    output logic               DREADY,
    output logic [CFG_W-1:0]   CFG_DATA,
    output logic [NUM_CLB-1:0] CFG_WE,
    output logic               BUSY,
    output logic               CFG_DONE,
    output logic               CFG_ERR
);
    import clb_cfg_pkg::*;

    localparam int IDX_W = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

    cfg_state_e       state;
    logic [7:0]       window;
    logic [7:0]       window_nxt;
    logic [IDX_W-1:0] idx;
    logic             start_ok;
    logic             shift_en;
    logic             frame_full;
    logic             parity_ok;
    logic [CFG_W-1:0] payload;

    // Handshake and activity flags decode state directly so they change with the state itself.
    assign DREADY     = (state == ST_HUNT) || (state == ST_SHIFT);
    assign BUSY       = DREADY || (state == ST_COMMIT);
    assign start_ok   = START && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign shift_en   = (state == ST_SHIFT) && DVALID;
    assign window_nxt = {window[6:0], DIN};

    clb_cfg_shifter #(.W(CFG_W)) u_shifter (
        .clk        (K),
        .rst_n      (RN),
        .shift_en   (shift_en),
        .din        (DIN),
        .clr        (start_ok),
        .frame_full (frame_full),
        .parity_ok  (parity_ok),
        .payload    (payload)
    );

    always_ff @(posedge K or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            window   <= '0;
            idx      <= '0;
            CFG_DATA <= '0;
            CFG_WE   <= '0;
            CFG_DONE <= 1'b0;
            CFG_ERR  <= 1'b0;
        end else begin
            CFG_WE <= '0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (START) begin
                        state    <= ST_HUNT;
                        window   <= '0;
                        idx      <= '0;
                        CFG_DONE <= 1'b0;
                        CFG_ERR  <= 1'b0;
                    end
                end
                ST_HUNT: begin
                    if (DVALID) begin
                        window <= window_nxt;
                        if (window_nxt == SYNC_PAT) state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (frame_full) begin
                        if (parity_ok) begin
                            // Data and strobe register together so they are valid in the same cycle.
                            state    <= ST_COMMIT;
                            CFG_DATA <= payload;
                            CFG_WE   <= NUM_CLB'(1) << idx;
                        end else begin
                            state   <= ST_ERROR;
                            CFG_ERR <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (idx == IDX_W'(NUM_CLB - 1)) begin
                        state    <= ST_DONE;
                        CFG_DONE <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Randomized bench for clb_cfg_loader: a stream-level model predicts the
// commits, done and error flags, and a monitor collects what the DUT writes.
module tb_clb_cfg_loader;
    import clb_cfg_pkg::*;

    localparam int         NUM_CLB = 4;
    localparam logic [7:0] SYNC    = 8'hB5;

    logic                clk    = 1'b0;
    logic                rst_n  = 1'b0;
    logic                start  = 1'b0;
    logic                din    = 1'b0;
    logic                dvalid = 1'b0;
    logic                dready;
    logic [CFG_W-1:0]    cfg_data;
    logic [NUM_CLB-1:0]  cfg_we;
    logic                busy;
    logic                cfg_done;
    logic                cfg_err;

    clb_cfg_loader #(.NUM_CLB(NUM_CLB), .CFG_W(CFG_W), .SYNC_PAT(SYNC)) dut (
        .K        (clk),
        .RN       (rst_n),
        .START    (start),
        .DIN      (din),
        .DVALID   (dvalid),
        .DREADY   (dready),
        .CFG_DATA (cfg_data),
        .CFG_WE   (cfg_we),
        .BUSY     (busy),
        .CFG_DONE (cfg_done),
        .CFG_ERR  (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int               idx;
        logic [CFG_W-1:0] data;
    } commit_t;

    commit_t          exp_q[$];
    commit_t          obs_q[$];
    commit_t          ref_q[$];
    bit               exp_done;
    bit               exp_err;
    bit               stream[$];
    logic [CFG_W-1:0] frames[NUM_CLB];

    // Monitor: every strobe must be one-hot and land in a cycle with DREADY low.
    always @(negedge clk) begin : mon
        commit_t c;
        int      hot;
        if (rst_n && cfg_we != '0) begin
            hot = 0;
            c.idx = -1;
            for (int i = 0; i < NUM_CLB; i++) begin
                if (cfg_we[i]) begin
                    c.idx = i;
                    hot++;
                end
            end
            c.data = cfg_data;
            obs_q.push_back(c);
            check("we_onehot", 64'(hot), 64'd1);
            check("dready_in_commit", 64'(dready), 64'd0);
        end
    end

    // Reference: slide an 8-bit window until it equals the sync word, then
    // cut 38-bit frames and accept each one whose bits XOR to zero.
    function automatic void run_model();
        logic [7:0]       win;
        int               p;
        bit               found;
        bit               par;
        logic [CFG_W-1:0] d;
        commit_t          c;
        win = '0;
        p = 0;
        found = 0;
        exp_q.delete();
        exp_done = 0;
        exp_err = 0;
        while (!found && p < stream.size()) begin
            win = {win[6:0], stream[p]};
            p++;
            found = (win == SYNC);
        end
        if (found) begin
            for (int f = 0; f < NUM_CLB; f++) begin
                if (p + CFG_W + 1 > stream.size()) break;
                par = 0;
                for (int b = 0; b <= CFG_W; b++) begin
                    par ^= stream[p + b];
                    if (b < CFG_W) d[b] = stream[p + b];
                end
                p += CFG_W + 1;
                if (par) begin
                    exp_err = 1;
                    break;
                end
                c.idx = f;
                c.data = d;
                exp_q.push_back(c);
                if (f == NUM_CLB - 1) exp_done = 1;
            end
        end
    endfunction

    function automatic void add_msb(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
    endfunction

    function automatic void build_stream(input int junk_n, input logic [63:0] junk, input int bad_frame);
        stream.delete();
        add_msb(junk, junk_n);
        add_msb(64'(SYNC), 8);
        for (int f = 0; f < NUM_CLB; f++) begin
            for (int i = 0; i < CFG_W; i++) stream.push_back(frames[f][i]);
            stream.push_back((^frames[f]) ^ (f == bad_frame));
        end
    endfunction

    function automatic void random_frames();
        logic [63:0] r;
        for (int f = 0; f < NUM_CLB; f++) begin
            r = {$urandom, $urandom};
            frames[f] = r[CFG_W-1:0];
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: DVALID always high; 1: toggles 1-0-1; other: random stalls.
    task automatic drive(input int mode, input int limit, input int start_at);
        int p;
        int acc;
        bit fired;
        bit ended;
        bit v;
        p = 0;
        acc = 0;
        fired = 0;
        ended = 0;
        for (int cyc = 0; cyc < 20000 && !ended; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (p >= stream.size() || acc >= limit || !busy) begin
                dvalid = 1'b0;
                ended = 1;
            end else begin
                case (mode)
                    0:       v = 1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                dvalid = v;
                din = v ? stream[p] : 1'($urandom);
                if (!fired && acc == start_at) begin
                    start = 1'b1;
                    fired = 1;
                end
                if (v && dready) begin
                    p++;
                    acc++;
                end
            end
        end
        check("drive_budget", 64'(ended), 64'd1);
    endtask

    task automatic finish_load(input string tag);
        int cyc;
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_dready"}, 64'(dready), 64'd0);
        check({tag, "_done"}, 64'(cfg_done), 64'(exp_done));
        check({tag, "_err"}, 64'(cfg_err), 64'(exp_err));
        check({tag, "_ncommit"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i), 64'(obs_q[i].idx), 64'(exp_q[i].idx));
            check($sformatf("%s_data%0d", tag, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
        end
    endtask

    task automatic do_load(input string tag, input int mode, input int start_at);
        run_model();
        obs_q.delete();
        pulse_start();
        drive(mode, 1 << 30, start_at);
        finish_load(tag);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        clb_frame_t pf;
        int         junk_n;
        int         bad;
        repeat (2) @(negedge clk);
        check("rst_we", 64'(cfg_we), 64'd0);
        check("rst_data", 64'(cfg_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dready", 64'(dready), 64'd0);
        check("rst_done", 64'(cfg_done), 64'd0);
        check("rst_err", 64'(cfg_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_dready", 64'(dready), 64'd0);

        // Reset in the middle of frame 0 after 20 payload bits.
        random_frames();
        build_stream(3, 64'b101, -1);
        obs_q.delete();
        pulse_start();
        drive(0, 3 + 8 + 20, -1);
        check("midrst_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", 64'(cfg_we), 64'd0);
        check("midrst_data", 64'(cfg_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_dready", 64'(dready), 64'd0);
        check("midrst_done", 64'(cfg_done), 64'd0);
        check("midrst_err", 64'(cfg_err), 64'd0);
        check("midrst_nocommit", 64'(obs_q.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load("after_rst", 0, -1);

        // Junk 101 before sync, then four clean frames; frame 0 has a known payload.
        random_frames();
        pf = '0;
        pf.mem = 16'h0116;
        pf.mux2sel = 2'b10;
        pf.mux3sel = 2'b10;
        pf.mux4sel = 2'b10;
        pf.o2m_1 = 3'b111;
        frames[0] = pf;
        build_stream(3, 64'b101, -1);
        do_load("hunt", 0, -1);
        if (obs_q.size() > 0) begin
            check("map_mem", 64'(obs_q[0].data[MEM_LSB +: MEM_W]), 64'h0116);
            check("map_mux234", 64'(obs_q[0].data[23:18]), 64'b101010);
            check("map_o2m1", 64'(obs_q[0].data[33:31]), 64'b111);
            check("map_comb", 64'(obs_q[0].data[COMB_LSB +: COMB_W]), 64'd0);
        end
        ref_q = obs_q;

        // Same stream with DVALID toggling must commit identically.
        do_load("stall_toggle", 1, -1);
        check("stall_same_count", 64'(obs_q.size()), 64'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++)
            check($sformatf("stall_same_data%0d", i), 64'(obs_q[i].data), 64'(ref_q[i].data));

        // Parity error in frame 1, then a clean retry.
        random_frames();
        build_stream(0, 64'd0, 1);
        do_load("perr", 0, -1);
        check("perr_flag", 64'(cfg_err), 64'd1);
        random_frames();
        build_stream(2, 64'b11, -1);
        do_load("perr_retry", 2, -1);
        check("retry_err_clear", 64'(cfg_err), 64'd0);

        // START pulsed while shifting frame 0 must be ignored.
        random_frames();
        build_stream(4, 64'b0110, -1);
        do_load("start_busy", 0, 4 + 8 + 10);

        for (int t = 0; t < 6; t++) begin
            random_frames();
            junk_n = $urandom_range(0, 6);
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM_CLB - 1)) : -1;
            build_stream(junk_n, {$urandom, $urandom}, bad);
            do_load($sformatf("rand%0d", t), $urandom_range(0, 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
